// File: rtl/uart_word_fifo_ctrl.sv
// Word-level 8N1 UART: Tx FIFO of DATA_WIDTH-bit words sent LSB byte first,
// Rx assembles bytes into words with sticky valid/overrun/frame-error flags.
module uart_word_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int baudrate   = 9600,
    parameter int clk_freq   = 50000000,
    parameter int TX_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        SerialDataIn,
    input  logic [DATA_WIDTH-1:0]       tx_word,
    input  logic                        tx_push,
    input  logic                        clr_rx_flag,
    input  logic                        clr_tx_flag,
    output logic                        SerialDataOut,
    output logic                        tx_full,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    output logic                        tx_busy,
    output logic                        Tx_flag_out,
    output logic                        tx_drop,
    output logic [DATA_WIDTH-1:0]       rx_word,
    output logic                        Rx_flag_out,
    output logic                        rx_overrun,
    output logic                        rx_frame_err
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CPB   = clk_freq / baudrate;
    localparam int PW    = $clog2(TX_DEPTH);
    localparam int CW    = PW + 1;
    localparam int BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int BCW   = $clog2(CPB + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------- Tx FIFO ----------------
    logic [DATA_WIDTH-1:0] fifo_mem [TX_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic                  push_ok, tx_pop;

    // Fullness is judged on the count at the start of the cycle, so a
    // simultaneous pop never rescues a push into a full FIFO.
    assign push_ok = tx_push && (tx_count < CW'(TX_DEPTH));
    assign tx_full = (tx_count == CW'(TX_DEPTH));

    always_ff @(posedge clk)
        if (push_ok) fifo_mem[wr_ptr] <= tx_word;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
            tx_count <= tx_count + CW'(push_ok) - CW'(tx_pop);
        end
    end

    // ---------------- Tx FSM ----------------
    state_t                tx_state, tx_next;
    logic [BCW-1:0]        tx_cnt;
    logic [2:0]            tx_bit;
    logic [BIW-1:0]        tx_byte;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic                  tx_tick, tx_line_d, tx_done, tx_done_q;

    assign tx_tick = (tx_cnt == BCW'(CPB - 1));
    assign tx_busy = (tx_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) tx_state <= S_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        tx_done = 1'b0;
        case (tx_state)
            S_IDLE:  if (tx_count != '0) begin tx_pop = 1'b1; tx_next = S_START; end
            S_START: if (tx_tick) tx_next = S_DATA;
            S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = S_STOP;
            S_STOP:
                if (tx_tick) begin
                    if (tx_byte != BIW'(BYTES - 1)) tx_next = S_START;
                    else if (tx_count != '0) begin tx_pop = 1'b1; tx_next = S_START; end
                    else begin tx_done = 1'b1; tx_next = S_IDLE; end
                end
        endcase
    end

    always_comb begin
        tx_line_d = 1'b1;
        case (tx_state)
            S_START: tx_line_d = 1'b0;
            S_DATA:  tx_line_d = tx_shift[0];
            default: tx_line_d = 1'b1;
        endcase
    end

    // The line and the done flag are registered, so both trail the FSM by one clock.
    always_ff @(posedge clk) begin
        if (!reset) begin
            SerialDataOut <= 1'b1;
            tx_done_q     <= 1'b0;
            tx_cnt        <= '0;
            tx_bit        <= '0;
            tx_byte       <= '0;
            tx_shift      <= '0;
        end else begin
            SerialDataOut <= tx_line_d;
            tx_done_q     <= tx_done;
            tx_cnt        <= (tx_state == S_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
            if (tx_pop) begin
                tx_shift <= fifo_mem[rd_ptr];
                tx_byte  <= '0;
            end else if (tx_state == S_STOP && tx_tick) begin
                tx_byte <= tx_byte + 1'b1;
            end
            if (tx_state == S_DATA && tx_tick) begin
                tx_bit   <= tx_bit + 1'b1;
                tx_shift <= tx_shift >> 1;
            end
        end
    end

    // ---------------- Rx ----------------
    state_t                rx_state, rx_next;
    logic                  rx_s1, rx_s2, rx_s3;
    logic [BCW-1:0]        rx_cnt;
    logic [2:0]            rx_bit;
    logic [BIW-1:0]        rx_byte;
    logic [7:0]            rx_sh;
    logic [DATA_WIDTH-1:0] rx_buf, rx_asm;
    logic                  rx_half, rx_tick, rx_sample, rx_stop_ok, rx_stop_bad, rx_word_done;

    assign rx_half = (rx_cnt == BCW'(CPB / 2 - 1));
    assign rx_tick = (rx_cnt == BCW'(CPB - 1));

    always_ff @(posedge clk) begin
        if (!reset) rx_state <= S_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (rx_s3 && !rx_s2) rx_next = S_START;
            S_START: if (rx_half) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = S_STOP;
            S_STOP:  if (rx_tick) rx_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_sample    = (rx_state == S_DATA) && rx_tick;
        rx_stop_ok   = (rx_state == S_STOP) && rx_tick && rx_s2;
        rx_stop_bad  = (rx_state == S_STOP) && rx_tick && !rx_s2;
        rx_word_done = rx_stop_ok && (rx_byte == BIW'(BYTES - 1));
        rx_asm       = rx_buf;
        rx_asm[rx_byte*8 +: 8] = rx_sh;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            {rx_s1, rx_s2, rx_s3} <= 3'b111;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_byte <= '0;
            rx_sh   <= '0;
            rx_buf  <= '0;
            rx_word <= '0;
        end else begin
            {rx_s1, rx_s2, rx_s3} <= {SerialDataIn, rx_s1, rx_s2};
            rx_cnt <= (rx_state == S_IDLE || (rx_state == S_START && rx_half) || rx_tick)
                      ? '0 : rx_cnt + 1'b1;
            if (rx_sample) begin
                rx_sh  <= {rx_s2, rx_sh[7:1]};
                rx_bit <= rx_bit + 1'b1;
            end
            if (rx_stop_ok) begin
                rx_buf <= rx_asm;
                if (rx_word_done) begin
                    rx_word <= rx_asm;
                    rx_byte <= '0;
                end else begin
                    rx_byte <= rx_byte + 1'b1;
                end
            end
            if (rx_stop_bad) rx_byte <= '0;
        end
    end

    // ---------------- Sticky flags: set beats clear ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            Tx_flag_out  <= 1'b0;
            tx_drop      <= 1'b0;
            Rx_flag_out  <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (tx_done_q)                     Tx_flag_out  <= 1'b1;
            else if (clr_tx_flag)              Tx_flag_out  <= 1'b0;
            if (tx_push && !push_ok)           tx_drop      <= 1'b1;
            else if (clr_tx_flag)              tx_drop      <= 1'b0;
            if (rx_word_done)                  Rx_flag_out  <= 1'b1;
            else if (clr_rx_flag)              Rx_flag_out  <= 1'b0;
            if (rx_word_done && Rx_flag_out)   rx_overrun   <= 1'b1;
            else if (clr_rx_flag)              rx_overrun   <= 1'b0;
            if (rx_stop_bad)                   rx_frame_err <= 1'b1;
            else if (clr_rx_flag)              rx_frame_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_word_fifo_ctrl.sv
// Directed bench for uart_word_fifo_ctrl at 10 clocks per bit, 32-bit words.
`timescale 1ns/1ps
module tb_uart_word_fifo_ctrl;
    localparam int DW  = 32;
    localparam int CPB = 10;

    logic          clk = 1'b0, reset = 1'b0;
    logic          rx_drv = 1'b1, loop = 1'b0;
    logic [DW-1:0] tx_word = '0;
    logic          tx_push = 1'b0, clr_rx_flag = 1'b0, clr_tx_flag = 1'b0;
    logic          serial_in, SerialDataOut, tx_full, tx_busy, Tx_flag_out, tx_drop;
    logic [2:0]    tx_count;
    logic [DW-1:0] rx_word;
    logic          Rx_flag_out, rx_overrun, rx_frame_err;

    int checks = 0, failures = 0;

    assign serial_in = loop ? SerialDataOut : rx_drv;

    uart_word_fifo_ctrl #(.DATA_WIDTH(DW), .baudrate(100000), .clk_freq(1000000), .TX_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .SerialDataIn(serial_in), .tx_word(tx_word), .tx_push(tx_push),
        .clr_rx_flag(clr_rx_flag), .clr_tx_flag(clr_tx_flag), .SerialDataOut(SerialDataOut),
        .tx_full(tx_full), .tx_count(tx_count), .tx_busy(tx_busy), .Tx_flag_out(Tx_flag_out),
        .tx_drop(tx_drop), .rx_word(rx_word), .Rx_flag_out(Rx_flag_out), .rx_overrun(rx_overrun),
        .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state(input string pre);
        check({pre, "_sdo"}, SerialDataOut, 1);
        check({pre, "_count"}, tx_count, 0);
        check({pre, "_busy"}, tx_busy, 0);
        check({pre, "_full"}, tx_full, 0);
        check({pre, "_txflag"}, Tx_flag_out, 0);
        check({pre, "_drop"}, tx_drop, 0);
        check({pre, "_rxflag"}, Rx_flag_out, 0);
        check({pre, "_ovr"}, rx_overrun, 0);
        check({pre, "_ferr"}, rx_frame_err, 0);
        check({pre, "_rxword"}, rx_word, 0);
    endtask

    task automatic push(input logic [DW-1:0] w);
        tx_word = w;
        tx_push = 1'b1;
        @(negedge clk);
        tx_push = 1'b0;
    endtask

    // Waits up to 'budget' clocks for a start bit, then checks all 400 line samples of the word.
    task automatic tx_frame(input logic [DW-1:0] w, input int budget);
        int n = 0;
        logic e;
        while (SerialDataOut !== 1'b0 && n < budget) begin @(negedge clk); n++; end
        if (SerialDataOut !== 1'b0) begin
            check($sformatf("tx_start_timeout w=%h", w), SerialDataOut, 0);
            return;
        end
        for (int i = 0; i < 4 * 10 * CPB; i++) begin
            int b   = i / CPB;
            int pos = b % 10;
            if (pos == 0)      e = 1'b0;
            else if (pos == 9) e = 1'b1;
            else               e = w[(b / 10) * 8 + pos - 1];
            check($sformatf("tx_line w=%h clk=%0d", w, i), SerialDataOut, e);
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopv);
        rx_drv = 1'b0; nclk(CPB);
        for (int i = 0; i < 8; i++) begin rx_drv = b[i]; nclk(CPB); end
        rx_drv = stopv; nclk(CPB);
        rx_drv = 1'b1;  nclk(CPB);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], 1'b1);
    endtask

    task automatic wait_rx_flag(input string tag, input int budget);
        int n = 0;
        while (Rx_flag_out !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        check(tag, Rx_flag_out, 1);
    endtask

    task automatic pulse_clr(input logic rx, input logic tx);
        clr_rx_flag = rx; clr_tx_flag = tx;
        @(negedge clk);
        clr_rx_flag = 1'b0; clr_tx_flag = 1'b0;
    endtask

    logic [DW-1:0] w3 [6] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003,
                              32'h4444_0004, 32'h5555_0005, 32'h6666_0006};

    initial begin
        // Reset state
        nclk(2);
        check_reset_state("rst");
        reset = 1'b1;
        nclk(1);

        // 1: single word, latency and exact line waveform
        push(32'hA5C3_0F11);
        check("t1_count_after_push", tx_count, 1);
        check("t1_sdo_after_push", SerialDataOut, 1);
        nclk(1);
        check("t1_busy_after_pop", tx_busy, 1);
        check("t1_count_after_pop", tx_count, 0);
        check("t1_sdo_at_pop", SerialDataOut, 1);
        check("t1_txflag_early", Tx_flag_out, 0);
        tx_frame(32'hA5C3_0F11, 1);
        check("t1_txflag_done", Tx_flag_out, 1);
        check("t1_busy_done", tx_busy, 0);

        // 2: loopback of two words
        loop = 1'b1;
        push(32'hDEAD_BEEF);
        push(32'h0123_4567);
        check("t2_txflag_kept_by_push", Tx_flag_out, 1);
        wait_rx_flag("t2_rxflag_w1", 1000);
        check("t2_rxword_w1", rx_word, 32'hDEAD_BEEF);
        pulse_clr(1'b1, 1'b0);
        check("t2_rxflag_cleared", Rx_flag_out, 0);
        wait_rx_flag("t2_rxflag_w2", 600);
        check("t2_rxword_w2", rx_word, 32'h0123_4567);
        check("t2_ovr", rx_overrun, 0);
        check("t2_ferr", rx_frame_err, 0);
        for (int n = 0; n < 300 && tx_busy; n++) @(negedge clk);
        nclk(10);
        loop = 1'b0;
        pulse_clr(1'b1, 1'b1);

        // 3: six back-to-back pushes, sixth dropped, five words out in order
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    tx_word = w3[k]; tx_push = 1'b1; @(negedge clk);
                end
                tx_push = 1'b0;
                check("t3_drop", tx_drop, 1);
                check("t3_full", tx_full, 1);
                check("t3_count", tx_count, 4);
            end
            begin
                for (int k = 0; k < 5; k++) tx_frame(w3[k], (k == 0) ? 10 : 0);
            end
        join
        check("t3_txflag", Tx_flag_out, 1);
        nclk(30);
        check("t3_no_sixth_word_busy", tx_busy, 0);
        check("t3_no_sixth_word_sdo", SerialDataOut, 1);
        check("t3_count_empty", tx_count, 0);
        pulse_clr(1'b0, 1'b1);
        check("t3_txflag_cleared", Tx_flag_out, 0);
        check("t3_drop_cleared", tx_drop, 0);

        // 4: frame error resyncs the byte index
        pulse_clr(1'b1, 1'b0);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b0);
        check("t4_ferr", rx_frame_err, 1);
        check("t4_no_word", Rx_flag_out, 0);
        send_word(32'h1122_3344);
        check("t4_rxflag", Rx_flag_out, 1);
        check("t4_rxword", rx_word, 32'h1122_3344);
        check("t4_ferr_sticky", rx_frame_err, 1);

        // 5: glitch rejection, overrun, and set-beats-clear
        pulse_clr(1'b1, 1'b0);
        rx_drv = 1'b0; nclk(3); rx_drv = 1'b1; nclk(20);
        check("t5_glitch_ferr", rx_frame_err, 0);
        check("t5_glitch_flag", Rx_flag_out, 0);
        send_word(32'hA1B2_C3D4);
        check("t5_rxword_a", rx_word, 32'hA1B2_C3D4);
        check("t5_ovr_a", rx_overrun, 0);
        send_word(32'h0BAD_F00D);
        check("t5_ovr_b", rx_overrun, 1);
        check("t5_rxword_b", rx_word, 32'h0BAD_F00D);
        check("t5_rxflag_b", Rx_flag_out, 1);
        pulse_clr(1'b1, 1'b0);
        check("t5_ovr_cleared", rx_overrun, 0);
        check("t5_rxflag_cleared", Rx_flag_out, 0);
        clr_rx_flag = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'h8D - 8'(i * 17), 1'b1);
        fork
            send_byte(8'h5A, 1'b1);
            begin
                for (int n = 0; n < 200 && Rx_flag_out !== 1'b1; n++) @(negedge clk);
                clr_rx_flag = 1'b0;
            end
        join
        clr_rx_flag = 1'b0;
        check("t5_set_beats_clear", Rx_flag_out, 1);
        check("t5_rxword_c", rx_word, 32'h5A6B_7C8D);
        check("t5_ovr_c", rx_overrun, 0);

        // 6: reset in the middle of byte 1 data bits
        push(32'hCAFE_F00D);
        push(32'h1234_5678);
        for (int n = 0; n < 10 && SerialDataOut !== 1'b0; n++) @(negedge clk);
        nclk(145);
        check("t6_busy_before", tx_busy, 1);
        check("t6_count_before", tx_count, 1);
        reset = 1'b0;
        nclk(1);
        check_reset_state("t6");
        reset = 1'b1;
        begin
            int lows = 0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (SerialDataOut !== 1'b1 || tx_busy !== 1'b0) lows++;
            end
            check("t6_line_quiet_after_reset", lows, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
